// File: rtl/sram_boot_sequencer_pkg.sv
// Shared constants for the SRAM boot sequencer: FSM state codes, byte-lane
// selects and the default load geometry.
package sram_boot_sequencer_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_WAITREL = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Byte index 0 is the most significant byte of the host word (big-endian).
    localparam logic [1:0] LANE_31_24 = 2'd0;
    localparam logic [1:0] LANE_23_16 = 2'd1;
    localparam logic [1:0] LANE_15_8  = 2'd2;
    localparam logic [1:0] LANE_7_0   = 2'd3;

    localparam int          DEFAULT_ROM_BYTES = 49152;
    localparam logic [20:0] DEFAULT_BASE_ADDR = 21'h000000;

    function automatic logic [7:0] select_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] lane;
        case (idx)
            LANE_31_24: lane = word[31:24];
            LANE_23_16: lane = word[23:16];
            LANE_15_8:  lane = word[15:8];
            default:    lane = word[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/sram_boot_sequencer.sv
// Loads ROM_BYTES of boot image from a 4-phase host word interface into SRAM,
// then releases the CPU and hands the SRAM over as a transparent pass-through.
module sram_boot_sequencer
    import sram_boot_sequencer_pkg::*;
#(
    parameter int          ROM_BYTES = DEFAULT_ROM_BYTES,
    parameter logic [20:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        ck16,
    input  logic        rst,
    input  logic [31:0] host_bootdata,
    input  logic        host_bootdata_req,
    output logic        host_bootdata_ack,
    output logic        host_rom_initialised,
    output logic        cpu_reset_hold,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we_n,
    output logic [7:0]  cpu_din,
    output logic [20:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_oe,
    input  logic [7:0]  sram_din,
    output logic        sram_we_n
);

    localparam int                CNT_W   = $clog2(ROM_BYTES + 1);
    localparam logic [CNT_W-1:0]  CNT_END = CNT_W'(ROM_BYTES);

    logic [2:0]       state;
    logic [31:0]      word_reg;
    logic [1:0]       byte_idx;
    logic [20:0]      addr_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic             ack;
    logic             initialised;
    logic             reset_hold;

    always_ff @(posedge ck16 or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            word_reg    <= 32'd0;
            byte_idx    <= 2'd0;
            addr_cnt    <= BASE_ADDR;
            byte_cnt    <= '0;
            ack         <= 1'b0;
            initialised <= 1'b0;
            reset_hold  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host_bootdata_req) begin
                        word_reg <= host_bootdata;
                        byte_idx <= 2'd0;
                        ack      <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    addr_cnt <= addr_cnt + 21'd1;
                    byte_cnt <= byte_cnt + CNT_W'(1);
                    if (byte_idx != LANE_7_0) begin
                        byte_idx <= byte_idx + 2'd1;
                        state    <= ST_SETUP;
                    end else begin
                        state <= ST_WAITREL;
                    end
                end
                ST_WAITREL: begin
                    // An early req release lands here with req already low, so we leave at once.
                    if (!host_bootdata_req) begin
                        ack <= 1'b0;
                        if (byte_cnt == CNT_END) begin
                            initialised <= 1'b1;
                            reset_hold  <= 1'b0;
                            state       <= ST_DONE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sram_addr = addr_cnt;
        sram_dout = 8'h00;
        sram_oe   = 1'b0;
        sram_we_n = 1'b1;
        cpu_din   = 8'hFF;
        case (state)
            ST_SETUP: begin
                sram_dout = select_lane(word_reg, byte_idx);
                sram_oe   = 1'b1;
            end
            ST_STROBE: begin
                sram_dout = select_lane(word_reg, byte_idx);
                sram_oe   = 1'b1;
                sram_we_n = 1'b0;
            end
            ST_DONE: begin
                sram_addr = cpu_addr;
                sram_dout = cpu_dout;
                sram_oe   = ~cpu_we_n;
                sram_we_n = cpu_we_n;
                cpu_din   = sram_din;
            end
            default: begin
                sram_addr = addr_cnt;
            end
        endcase
    end

    assign host_bootdata_ack    = ack;
    assign host_rom_initialised = initialised;
    assign cpu_reset_hold       = reset_hold;

endmodule

// File: tb/tb_sram_boot_sequencer.sv
// Scoreboard bench for sram_boot_sequencer with an 8-byte ROM at address 0.
module tb_sram_boot_sequencer;

    typedef struct packed {
        logic [20:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        ck16 = 1'b0;
    logic        rst;
    logic [31:0] host_bootdata;
    logic        host_bootdata_req;
    logic        host_bootdata_ack;
    logic        host_rom_initialised;
    logic        cpu_reset_hold;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we_n;
    logic [7:0]  cpu_din;
    logic [20:0] sram_addr;
    logic [7:0]  sram_dout;
    logic        sram_oe;
    logic [7:0]  sram_din;
    logic        sram_we_n;

    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b1;
    wr_t exp_q[$];

    sram_boot_sequencer #(.ROM_BYTES(8), .BASE_ADDR(21'h000000)) dut (
        .ck16(ck16), .rst(rst),
        .host_bootdata(host_bootdata), .host_bootdata_req(host_bootdata_req),
        .host_bootdata_ack(host_bootdata_ack),
        .host_rom_initialised(host_rom_initialised), .cpu_reset_hold(cpu_reset_hold),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we_n(cpu_we_n), .cpu_din(cpu_din),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_oe(sram_oe),
        .sram_din(sram_din), .sram_we_n(sram_we_n)
    );

    always #5 ck16 = ~ck16;

    // Every low we_n cycle is one write and must match the next expected byte.
    always @(negedge ck16) begin
        if (mon_en && sram_we_n === 1'b0) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: addr=%h data=%h, required no write", sram_addr, sram_dout);
            end else begin
                e = exp_q.pop_front();
                if (sram_addr !== e.addr || sram_dout !== e.data || sram_oe !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL sram_write: addr=%h data=%h oe=%b, required addr=%h data=%h oe=1",
                             sram_addr, sram_dout, sram_oe, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input logic [20:0] base);
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.addr = base + 21'(i);
            e.data = w[31 - 8*i -: 8];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [20:0] base, input int hold, input bit last);
        push_word(w, base);
        @(posedge ck16); #1;
        host_bootdata     = w;
        host_bootdata_req = 1'b1;
        @(posedge ck16); @(negedge ck16);
        checks++;
        if (host_bootdata_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ack_rise: ack=%b, required 1", host_bootdata_ack);
        end
        repeat (6) @(posedge ck16);
        @(negedge ck16);
        checks++;
        if (exp_q.size() != 1) begin
            errors++;
            $display("[TB] FAIL write_pacing_mid: pending=%0d, required 1", exp_q.size());
        end
        repeat (2) @(posedge ck16);
        @(negedge ck16);
        checks++;
        if (exp_q.size() != 0 || host_bootdata_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL word_complete: pending=%0d ack=%b, required 0 and 1", exp_q.size(), host_bootdata_ack);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge ck16);
            checks++;
            if (host_bootdata_ack !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ack_hold: cycle %0d ack=%b, required 1", i, host_bootdata_ack);
            end
        end
        host_bootdata_req = 1'b0;
        host_bootdata     = $urandom;
        @(posedge ck16); @(negedge ck16);
        checks++;
        if (host_bootdata_ack !== 1'b0 || host_rom_initialised !== last || cpu_reset_hold !== !last) begin
            errors++;
            $display("[TB] FAIL release: ack=%b init=%b hold=%b, required 0 %b %b",
                     host_bootdata_ack, host_rom_initialised, cpu_reset_hold, last, !last);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (host_bootdata_ack !== 1'b0 || host_rom_initialised !== 1'b0 || cpu_reset_hold !== 1'b1 ||
            sram_we_n !== 1'b1 || sram_oe !== 1'b0 || sram_addr !== 21'h0 || sram_dout !== 8'h00 ||
            cpu_din !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL %s: ack=%b init=%b hold=%b we_n=%b oe=%b addr=%h dout=%h cpu_din=%h, required 0 0 1 1 0 000000 00 ff",
                     tag, host_bootdata_ack, host_rom_initialised, cpu_reset_hold, sram_we_n, sram_oe,
                     sram_addr, sram_dout, cpu_din);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        host_bootdata = 32'h0; host_bootdata_req = 1'b0;
        cpu_addr = 21'h0; cpu_dout = 8'h0; cpu_we_n = 1'b1; sram_din = 8'h3C;
        repeat (2) @(negedge ck16);
        check_reset_values("reset_state");
        rst = 1'b0;
    endtask

    task automatic test_cpu_isolation();
        for (int i = 0; i < 6; i++) begin
            cpu_addr = 21'($urandom);
            cpu_dout = 8'($urandom);
            cpu_we_n = i[0];
            sram_din = 8'($urandom);
            @(negedge ck16);
            checks++;
            if (sram_we_n !== 1'b1 || sram_oe !== 1'b0 || sram_addr !== 21'h0 || cpu_din !== 8'hFF) begin
                errors++;
                $display("[TB] FAIL cpu_isolation: we_n=%b oe=%b addr=%h cpu_din=%h, required 1 0 000000 ff",
                         sram_we_n, sram_oe, sram_addr, cpu_din);
            end
        end
        cpu_we_n = 1'b1;
    endtask

    task automatic test_reset_abort();
        push_word(32'hDEADBEEF, 21'h0);
        @(posedge ck16); #1;
        host_bootdata     = 32'hDEADBEEF;
        host_bootdata_req = 1'b1;
        repeat (5) @(posedge ck16);
        @(negedge ck16);
        checks++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL abort_progress: pending=%0d, required 2", exp_q.size());
        end
        #1;
        rst = 1'b1;
        host_bootdata_req = 1'b0;
        #1;
        check_reset_values("reset_abort");
        exp_q.delete();
        @(negedge ck16);
        rst = 1'b0;
    endtask

    task automatic test_load();
        send_word(32'h11223344, 21'h000000, 20, 1'b0);
        send_word(32'h55667788, 21'h000004, 0, 1'b1);
    endtask

    task automatic test_done_passthrough();
        mon_en = 1'b0;
        cpu_addr = 21'h00ABCD; cpu_dout = 8'h5A; cpu_we_n = 1'b0;
        #1;
        checks++;
        if (sram_addr !== 21'h00ABCD || sram_dout !== 8'h5A || sram_oe !== 1'b1 || sram_we_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_write: addr=%h dout=%h oe=%b we_n=%b, required 00abcd 5a 1 0",
                     sram_addr, sram_dout, sram_oe, sram_we_n);
        end
        cpu_we_n = 1'b1; sram_din = 8'hC3;
        #1;
        checks++;
        if (cpu_din !== 8'hC3 || sram_oe !== 1'b0 || sram_we_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_read: cpu_din=%h oe=%b we_n=%b, required c3 0 1", cpu_din, sram_oe, sram_we_n);
        end
        @(negedge ck16);
        mon_en = 1'b1;
    endtask

    task automatic test_done_ignores_req();
        host_bootdata     = $urandom;
        host_bootdata_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ck16);
            checks++;
            if (host_bootdata_ack !== 1'b0 || host_rom_initialised !== 1'b1) begin
                errors++;
                $display("[TB] FAIL done_ignores_req: ack=%b init=%b, required 0 1", host_bootdata_ack, host_rom_initialised);
            end
        end
        host_bootdata_req = 1'b0;
        repeat (2) @(negedge ck16);
    endtask

    initial begin
        test_reset();
        test_cpu_isolation();
        test_reset_abort();
        test_load();
        test_done_passthrough();
        test_done_ignores_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_boot_sequencer.md
SRAM_BOOT_SEQUENCER -- requirements
Module: sram_boot_sequencer

Interface
REQ-001 Parameter ROM_BYTES, default 49152: number of ROM bytes loaded; SHALL be a nonzero multiple of 4.
REQ-002 Parameter BASE_ADDR, default 21'h000000: SRAM address of the first loaded byte.
REQ-003 ck16  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 host_bootdata  in  32  boot word from host; stable while host_bootdata_req=1.
REQ-006 host_bootdata_req  in  1  host word-valid request (4-phase).
REQ-007 host_bootdata_ack  out  1  word-accepted acknowledge (4-phase).
REQ-008 host_rom_initialised  out  1  all ROM_BYTES written; SRAM belongs to CPU.
REQ-009 cpu_reset_hold  out  1  holds the CPC core in reset while loading.
REQ-010 cpu_addr  in  21;  cpu_dout  in  8;  cpu_we_n  in  1  CPU-side SRAM request.
REQ-011 cpu_din  out  8  SRAM read data returned to CPU.
REQ-012 sram_addr  out  21;  sram_dout  out  8;  sram_oe  out  1 (drive data bus);  sram_din  in  8;  sram_we_n  out  1.

Function
REQ-013 States: IDLE, SETUP, STROBE, WAITREL, DONE; encoding is free.
REQ-014 IDLE with req=1: latch host_bootdata, set byte index 0, ack<=1, go SETUP. Ack rises 1 cycle after req is sampled.
REQ-015 SETUP: sram_addr = address counter, sram_dout = selected byte, sram_oe=1, sram_we_n=1.
REQ-016 STROBE: same address and data, sram_we_n=0; the address counter increments by 1 at the end of the state.
REQ-017 Byte order is big-endian: index 0..3 selects bits [31:24], [23:16], [15:8], [7:0].
REQ-018 After STROBE: if index<3, increment index and go SETUP; otherwise go WAITREL.
REQ-019 Each word takes exactly 8 write cycles, from the first SETUP to the last STROBE inclusive.
REQ-020 WAITREL: hold ack=1 until req=0, then ack<=0 in the same cycle req=0 is sampled.
REQ-021 From WAITREL: go DONE if the byte counter has reached ROM_BYTES, else go IDLE.
REQ-022 DONE is terminal until reset:
  - host_rom_initialised=1 and cpu_reset_hold=0, both registered and asserted on DONE entry;
  - req in DONE is ignored and ack stays 0.
REQ-023 In DONE the SRAM is a pass-through:
  - sram_addr=cpu_addr, sram_dout=cpu_dout, sram_we_n=cpu_we_n, sram_oe=~cpu_we_n;
  - cpu_din=sram_din.
REQ-024 Before DONE, cpu_din=8'hFF and CPU inputs have no effect on the SRAM.
REQ-025 Address arithmetic is 21-bit: BASE_ADDR+ROM_BYTES-1 SHALL NOT exceed 21'h1FFFFF; no wrap is performed.
REQ-026 Byte counter width is clog2(ROM_BYTES+1); the terminal compare is exact equality.
REQ-027 Outside STROBE, sram_we_n=1 whenever the state is not DONE.
REQ-028 req deasserting before ack (protocol violation): ignored. The word is still written fully and WAITREL exits immediately.

Reset
REQ-029 While rst=1: state IDLE, ack=0, host_rom_initialised=0, cpu_reset_hold=1, sram_we_n=1, sram_oe=0, sram_addr=BASE_ADDR, sram_dout=0, counters 0.
REQ-030 Reset asserted mid-word or in DONE aborts immediately. The host SHALL restart the load from word 0; partially written bytes are not undone.
REQ-031 After rst falls, the first req is sampled no earlier than the next rising edge.

Structure
REQ-032 A shared package SHALL hold:
  - the state enumeration;
  - the byte-lane select constants;
  - the default ROM_BYTES and BASE_ADDR constants.
REQ-033 No sub-module: host and block share ck16, so no synchroniser is needed; a single FSM plus counters suffices.

Verification
REQ-034 ROM_BYTES=8, BASE_ADDR=0; send 32'h11223344 then 32'h55667788 with 4-phase handshakes:
  - writes 11,22,33,44,55,66,77,88 to addresses 0..7, each with we_n low one cycle;
  - initialised=1 after the second req falls.
REQ-035 req held high 20 cycles after ack: no further writes and ack stays 1; req low -> ack low the same sampled cycle, state IDLE.
REQ-036 Assert rst after the second byte of word 0:
  - ack=0, we_n=1, sram_addr=0 immediately;
  - a restarted load completes correctly.
REQ-037 In DONE, cpu_addr=21'h00ABCD, cpu_we_n=0, cpu_dout=8'h5A:
  - SRAM sees addr 00ABCD, data 5A, oe=1;
  - a read returns sram_din on cpu_din.
REQ-038 In DONE, pulse req with any data: ack stays 0 and no SRAM write originates from the sequencer.
REQ-039 Before DONE, toggle cpu_we_n and cpu_addr: SRAM signals are unaffected and cpu_din=8'hFF.
